button_events: RTL and testbench
================================

BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 The block SHALL take parameter CLK_FREQ_KHZ, default 100_000, meaning clock cycles per millisecond.
REQ-002 The block SHALL take parameter LONG_MS, default 1000, meaning the hold time in ms before a long press; legal range 1..65535.
REQ-003 The block SHALL take parameter REPEAT_MS, default 200, meaning the auto-repeat period in ms; legal range 1..65535.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 btn  input  1  debounced button level, already synchronous to clk, 1 = pressed.
REQ-007 press  output  1  one-cycle pulse on a press.
REQ-008 release  output  1  one-cycle pulse on a release.
REQ-009 long_press  output  1  one-cycle pulse when the hold reaches LONG_MS.
REQ-010 repeat  output  1  one-cycle pulse every REPEAT_MS after long_press, while the button stays held.
REQ-011 held  output  1  level, 1 while the state is not IDLE.

Function
REQ-012 Registered stage: btn_q SHALL hold btn delayed one cycle; rise = btn & ~btn_q; fall = ~btn & btn_q.
REQ-013 The FSM SHALL have states IDLE, PRESSED, HELD, encoded in 2 bits; the unused encoding SHALL go to IDLE with no pulses.
REQ-014 All outputs SHALL be registered; each event pulse SHALL be high in the cycle after the clk edge at which its condition is detected, for exactly one cycle.
REQ-015 IDLE: on rise, the block SHALL pulse press, clear the prescaler and ms_cnt, and go to PRESSED; fall in IDLE SHALL be ignored.
REQ-016 Prescaler: a 24-bit counter SHALL count 0..CLK_FREQ_KHZ-1 and assert an internal ms_tick when it is at CLK_FREQ_KHZ-1, then wrap to 0; it SHALL run only outside IDLE.
REQ-017 ms_cnt: a 16-bit counter SHALL increment on ms_tick; it SHALL never wrap, because it is cleared on every threshold hit.
REQ-018 PRESSED: when ms_cnt reaches LONG_MS, the block SHALL pulse long_press, clear ms_cnt, and go to HELD; long_press SHALL be exactly LONG_MS*CLK_FREQ_KHZ cycles after press.
REQ-019 HELD: the block SHALL stay in HELD until fall; REQ-029 and REQ-030 govern repeat.
REQ-020 Fall in PRESSED or HELD SHALL pulse release, clear the counters, and go to IDLE.
REQ-021 When fall and a threshold hit occur in the same cycle, release SHALL win; long_press and repeat SHALL NOT pulse.
REQ-022 At most one of press, release, long_press, repeat SHALL be high in any cycle.
REQ-023 held SHALL rise in the same cycle as press and fall in the same cycle as release.

Reset
REQ-024 When rst_n=0 at a clk edge, the block SHALL set state IDLE, prescaler 0, ms_cnt 0, and press, release, long_press, repeat and held to 0.
REQ-025 During reset btn_q SHALL be forced to 1, so a button already held when reset deasserts produces no press; a new press requires btn to go low, then high.
REQ-026 Reset asserted mid-hold SHALL produce no release pulse; all outputs SHALL be 0 in the cycle after the reset edge.
REQ-027 Reset SHALL dominate all other events in the same cycle.

Configuration
REQ-028 The macro BUTTON_EVENTS_AUTO_REPEAT_EN SHALL compile auto-repeat in or out.
REQ-029 With BUTTON_EVENTS_AUTO_REPEAT_EN defined, in HELD the block SHALL pulse repeat when ms_cnt reaches REPEAT_MS and then clear ms_cnt, giving the first repeat REPEAT_MS*CLK_FREQ_KHZ cycles after long_press and each later repeat the same spacing after the previous one.
REQ-030 With BUTTON_EVENTS_AUTO_REPEAT_EN undefined, repeat SHALL be tied to 0, and ms_cnt and the prescaler SHALL hold in HELD; all other behaviour SHALL be identical.

Verification (CLK_FREQ_KHZ=10, LONG_MS=5, REPEAT_MS=2)
REQ-031 Reset, then btn 0->1 sampled at edge 100 -> press high in cycle 101 only; held=1 from cycle 101.
REQ-032 Press, hold 30 cycles, then release -> one release pulse, held->0, and no long_press.
REQ-033 Press and hold 120 cycles -> long_press 50 cycles after press; with the macro, repeat at +20 and +40 cycles after long_press; without the macro, repeat never asserts.
REQ-034 btn=1 throughout reset, deassert rst_n -> no press; then btn 0 for 3 cycles and 1 -> exactly one press.
REQ-035 btn falls on the edge where ms_cnt would reach LONG_MS -> release only; long_press stays 0.
REQ-036 rst_n=0 for one cycle while in HELD -> all outputs 0 in the next cycle, no release pulse, and no press until btn goes low then high.

Source files
------------

// File: rtl/button_events.sv
// Button event generator: press/release pulses, long-press after LONG_MS, optional auto-repeat.
// Auto-repeat is compiled in when the macro BUTTON_EVENTS_AUTO_REPEAT_EN is defined.
module button_events #(
  parameter int unsigned CLK_FREQ_KHZ = 100_000,
  parameter int unsigned LONG_MS      = 1000,
  parameter int unsigned REPEAT_MS    = 200
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_held
);

  if (CLK_FREQ_KHZ < 1 || CLK_FREQ_KHZ > 24'hFF_FFFF ||
      LONG_MS < 1 || LONG_MS > 65535 ||
      REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_param_check
    $error("button_events: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HELD    = 2'b10
  } state_t;

  localparam logic [23:0] PRESC_MAX = 24'(CLK_FREQ_KHZ - 1);
  localparam logic [15:0] LONG_M1   = 16'(LONG_MS - 1);

  state_t      r_state, w_state_nxt;
  logic        r_btn_q;
  logic [23:0] r_presc, w_presc_nxt, w_presc_run;
  logic [15:0] r_ms_cnt, w_ms_cnt_nxt, w_ms_cnt_run;
  logic        r_press, r_release, r_long_press, r_repeat, r_held;
  logic        w_press, w_release, w_long_press, w_repeat;
  logic        w_rise, w_fall, w_tick, w_long_hit;

  assign w_rise       = i_btn & ~r_btn_q;
  assign w_fall       = ~i_btn & r_btn_q;
  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_presc_run  = w_tick ? 24'd0 : r_presc + 24'd1;
  assign w_ms_cnt_run = w_tick ? r_ms_cnt + 16'd1 : r_ms_cnt;
  // Thresholds fire on the tick that would carry ms_cnt onto the limit.
  assign w_long_hit   = w_tick && (r_ms_cnt == LONG_M1);

`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
  localparam logic [15:0] REPEAT_M1 = 16'(REPEAT_MS - 1);
  logic w_rep_hit;
  assign w_rep_hit = w_tick && (r_ms_cnt == REPEAT_M1);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_ms_cnt_nxt = r_ms_cnt;
    w_press      = 1'b0;
    w_release    = 1'b0;
    w_long_press = 1'b0;
    w_repeat     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_press      = 1'b1;
          w_presc_nxt  = 24'd0;
          w_ms_cnt_nxt = 16'd0;
          w_state_nxt  = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
          w_release    = 1'b1;
          w_presc_nxt  = 24'd0;
          w_ms_cnt_nxt = 16'd0;
          w_state_nxt  = ST_IDLE;
        end else if (w_long_hit) begin
          w_long_press = 1'b1;
          w_presc_nxt  = w_presc_run;
          w_ms_cnt_nxt = 16'd0;
          w_state_nxt  = ST_HELD;
        end else begin
          w_presc_nxt  = w_presc_run;
          w_ms_cnt_nxt = w_ms_cnt_run;
        end
      end
      ST_HELD: begin
        if (w_fall) begin
          w_release    = 1'b1;
          w_presc_nxt  = 24'd0;
          w_ms_cnt_nxt = 16'd0;
          w_state_nxt  = ST_IDLE;
        end else begin
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
          w_presc_nxt = w_presc_run;
          if (w_rep_hit) begin
            w_repeat     = 1'b1;
            w_ms_cnt_nxt = 16'd0;
          end else begin
            w_ms_cnt_nxt = w_ms_cnt_run;
          end
`else
          w_presc_nxt  = r_presc;
          w_ms_cnt_nxt = r_ms_cnt;
`endif
        end
      end
      default: begin
        w_presc_nxt  = 24'd0;
        w_ms_cnt_nxt = 16'd0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // btn_q resets high so a button held through reset needs a fresh low->high edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_btn_q      <= 1'b1;
      r_presc      <= 24'd0;
      r_ms_cnt     <= 16'd0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_long_press <= 1'b0;
      r_repeat     <= 1'b0;
      r_held       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_btn_q      <= i_btn;
      r_presc      <= w_presc_nxt;
      r_ms_cnt     <= w_ms_cnt_nxt;
      r_press      <= w_press;
      r_release    <= w_release;
      r_long_press <= w_long_press;
      r_repeat     <= w_repeat;
      r_held       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long_press;
  assign o_repeat     = r_repeat;
  assign o_held       = r_held;

endmodule

// File: tb/tb_button_events.sv
// Randomized self-checking bench for button_events (CLK_FREQ_KHZ=10, LONG_MS=5, REPEAT_MS=2).
module tb_button_events;

  localparam int K  = 10;
  localparam int L  = 5;
  localparam int R  = 2;
  localparam int LK = L * K;
  localparam int RK = R * K;
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic press, rel, long_press, rep, held;
  logic [4:0] dut_out;
  assign dut_out = {press, rel, long_press, rep, held};

  int errors = 0;
  int checks = 0;

  // Reference model: time elapsed since the accepted press decides every event.
  bit         m_prev = 1'b1;
  bit         m_active = 1'b0;
  int         m_n = 0;
  logic [4:0] exp_out = 5'b0;

  button_events #(.CLK_FREQ_KHZ(K), .LONG_MS(L), .REPEAT_MS(R)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_press(press), .o_release(rel), .o_long_press(long_press),
    .o_repeat(rep), .o_held(held)
  );

  always #5 clk = ~clk;

  task automatic tick();
    bit rise, fall, e_p, e_r, e_l, e_rp;
    @(posedge clk);
    e_p = 0; e_r = 0; e_l = 0; e_rp = 0;
    if (!rst_n) begin
      m_prev = 1'b1; m_active = 1'b0; m_n = 0;
    end else begin
      rise = btn && !m_prev;
      fall = !btn && m_prev;
      if (!m_active) begin
        if (rise) begin e_p = 1; m_active = 1; m_n = 0; end
      end else begin
        m_n++;
        if (fall) begin e_r = 1; m_active = 0; end
        else if (m_n == LK) e_l = 1;
        else if (AR && m_n > LK && ((m_n - LK) % RK) == 0) e_rp = 1;
      end
      m_prev = btn;
    end
    exp_out = {e_p, e_r, e_l, e_rp, m_active};
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      btn = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (dut_out !== 5'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b expected %b", i, dut_out, 5'b0);
      end
    end
    btn = 0;
    rst_n = 1;
    tick();
  endtask

  task automatic test_press();
    for (int i = 0; i < 3; i++) tick();
    btn = 1;
    tick();
    checks++;
    if (dut_out !== 5'b10001) begin
      errors++;
      $display("FAIL press_pulse: got %b expected %b", dut_out, 5'b10001);
    end
    tick();
    checks++;
    if (dut_out !== 5'b00001) begin
      errors++;
      $display("FAIL press_after: got %b expected %b", dut_out, 5'b00001);
    end
    btn = 0;
    tick();
    checks++;
    if (dut_out !== exp_out || exp_out !== 5'b01000) begin
      errors++;
      $display("FAIL press_release: got %b expected %b", dut_out, 5'b01000);
    end
    tick();
  endtask

  task automatic test_short_press();
    int n_rel = 0, n_long = 0;
    btn = 1;
    for (int i = 0; i < 34; i++) begin
      if (i == 30) btn = 0;
      tick();
      n_rel += int'(rel);
      n_long += int'(long_press);
      checks++;
      if (dut_out !== exp_out) begin
        errors++;
        $display("FAIL short_press cyc%0d: got %b expected %b", i, dut_out, exp_out);
      end
    end
    checks++;
    if (n_rel != 1 || n_long != 0 || held !== 1'b0) begin
      errors++;
      $display("FAIL short_counts: got rel=%0d long=%0d held=%b expected rel=1 long=0 held=0",
               n_rel, n_long, held);
    end
  endtask

  task automatic test_long_hold();
    int t_long = -1, n_long = 0, n_rep = 0;
    int t_rep[$];
    btn = 1;
    for (int i = 0; i <= 120; i++) begin
      tick();
      if (long_press) begin t_long = i; n_long++; end
      if (rep) begin t_rep.push_back(i); n_rep++; end
      checks++;
      if (dut_out !== exp_out) begin
        errors++;
        $display("FAIL long_hold cyc%0d: got %b expected %b", i, dut_out, exp_out);
      end
    end
    checks++;
    if (n_long != 1 || t_long != 50) begin
      errors++;
      $display("FAIL long_time: got n=%0d t=%0d expected n=1 t=50", n_long, t_long);
    end
    checks++;
    if (AR) begin
      if (n_rep < 2 || t_rep[0] != 70 || t_rep[1] != 90) begin
        errors++;
        $display("FAIL repeat_time: got n=%0d expected first repeats at 70,90", n_rep);
      end
    end else if (n_rep != 0) begin
      errors++;
      $display("FAIL repeat_off: got %0d repeats expected 0", n_rep);
    end
    btn = 0;
    tick();
    checks++;
    if (dut_out !== 5'b01000) begin
      errors++;
      $display("FAIL long_release: got %b expected %b", dut_out, 5'b01000);
    end
    tick();
  endtask

  task automatic test_reset_held();
    int n_press = 0;
    btn = 1;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) btn = 0;
      if (i == 7) btn = 1;
      tick();
      n_press += int'(press);
      checks++;
      if (dut_out !== exp_out) begin
        errors++;
        $display("FAIL reset_held cyc%0d: got %b expected %b", i, dut_out, exp_out);
      end
    end
    checks++;
    if (n_press != 1) begin
      errors++;
      $display("FAIL reset_held_count: got %0d presses expected 1", n_press);
    end
    btn = 0;
    tick(); tick();
  endtask

  task automatic test_fall_at_threshold();
    int n_long = 0, n_rel = 0;
    btn = 1;
    tick();
    for (int i = 1; i <= 52; i++) begin
      if (i == 50) btn = 0;
      tick();
      n_long += int'(long_press);
      n_rel += int'(rel);
      checks++;
      if (dut_out !== exp_out) begin
        errors++;
        $display("FAIL fall_thresh cyc%0d: got %b expected %b", i, dut_out, exp_out);
      end
    end
    checks++;
    if (n_long != 0 || n_rel != 1) begin
      errors++;
      $display("FAIL fall_thresh_count: got long=%0d rel=%0d expected long=0 rel=1",
               n_long, n_rel);
    end
  endtask

  task automatic test_reset_in_held();
    btn = 1;
    for (int i = 0; i < 60; i++) tick();
    rst_n = 0;
    tick();
    checks++;
    if (dut_out !== 5'b0) begin
      errors++;
      $display("FAIL reset_in_held: got %b expected %b", dut_out, 5'b0);
    end
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) btn = 0;
      if (i == 5) btn = 1;
      tick();
      checks++;
      if (dut_out !== exp_out) begin
        errors++;
        $display("FAIL reset_in_held_after cyc%0d: got %b expected %b", i, dut_out, exp_out);
      end
    end
    btn = 0;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      btn = ~btn;
      tick();
      checks++;
      if (dut_out !== exp_out) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", i, dut_out, exp_out);
      end
    end
  endtask

  task automatic test_random();
    int dwell = 0;
    for (int i = 0; i < 4000; i++) begin
      if (dwell == 0) begin
        btn = ~btn;
        dwell = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 130))
                                            : int'($urandom_range(1, 25));
      end
      dwell--;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (dut_out !== exp_out) begin
        errors++;
        $display("FAIL random cyc%0d: got %b expected %b", i, dut_out, exp_out);
      end
    end
    rst_n = 1;
  endtask

  initial begin
    #1;
    test_reset();
    test_press();
    test_short_press();
    test_long_hold();
    test_reset_held();
    test_fall_at_threshold();
    test_reset_in_held();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
